// File: rtl/fifo_uart_framer.sv
// -----------------------------------------------------------------------------
// fifo_uart_framer
//
// Drains 48-bit TDC measurement records from the measurement FIFO and sends
// each one to the byte-wide UART transmitter as an 8-byte frame:
//   SYNC_BYTE, data bytes MSB first, XOR checksum of the data bytes.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   fifo_empty   FIFO empty flag
//   fifo_dout    FIFO read data {16'b0, calib_diff[15:0], time1[15:0]}
//   fifo_rd_en   single-cycle FIFO pop strobe
//   tx_busy      UART transmitter busy
//   tx_data      byte to the UART, held until the next strobe
//   new_tx_data  single-cycle strobe; the UART samples tx_data on it
//   hold         pause; no new frame starts while high
//   frame_done   single-cycle pulse after the checksum byte is handed over
//   frame_count  frames completed, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module fifo_uart_framer #(
  parameter int         DATA_WIDTH      = 48,     // multiple of 8
  parameter logic [7:0] SYNC_BYTE       = 8'hA5,
  parameter int         FIFO_RD_LATENCY = 1       // 1 or 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  new_tx_data,
  input  logic                  hold,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int LAST      = NUM_BYTES + 1;        // index of checksum byte
  localparam int IDX_W     = $clog2(LAST + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);
  localparam logic [1:0]       RD_LAT   = 2'(FIFO_RD_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    SEND,
    GUARD
  } state_t;

  state_t                state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  strobe_q, strobe_d;
  logic                  done_q, done_d;
  logic [15:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] rec_q, rec_d;
  logic [7:0]            csum_q, csum_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            wait_q, wait_d;

  // The record is shifted left as data bytes go out, so the next data byte
  // is always the top byte of the register.
  logic [7:0] data_byte;
  assign data_byte = rec_q[DATA_WIDTH-1 -: 8];

  // NOTE: every register is cleared by the asynchronous reset so an aborted
  // frame leaves nothing behind; the record register is small enough that
  // resetting it costs nothing and keeps tx_data deterministic.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= 16'h0000;
      rec_q     <= '0;
      csum_q    <= 8'h00;
      idx_q     <= '0;
      wait_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      tx_data_q <= tx_data_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      count_q   <= count_d;
      rec_q     <= rec_d;
      csum_q    <= csum_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred. Strobes default low, which
  // makes them single-cycle by construction.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    count_d   = count_q;
    rec_d     = rec_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    wait_d    = wait_q;

    unique case (state_q)
      IDLE: begin
        // hold and fifo_empty only matter here; a started frame always ends.
        if (!fifo_empty && !hold) begin
          rd_en_d = 1'b1;
          wait_d  = 2'd0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        // The pop strobe is visible to the FIFO one edge after we enter this
        // state, so data is valid RD_LAT edges after that.
        if (wait_q == RD_LAT) begin
          rec_d   = fifo_dout;
          csum_d  = 8'h00;
          idx_d   = '0;
          state_d = SEND;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      SEND: begin
        if (!tx_busy) begin
          strobe_d = 1'b1;
          state_d  = GUARD;
          if (idx_q == '0) begin
            tx_data_d = SYNC_BYTE;
          end else if (idx_q == LAST_IDX) begin
            tx_data_d = csum_q;
          end else begin
            tx_data_d = data_byte;
            csum_d    = csum_q ^ data_byte;
            rec_d     = rec_q << 8;
          end
        end
      end

      GUARD: begin
        // One idle cycle lets the UART raise tx_busy before SEND looks at it.
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          count_d = count_q + 16'd1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = SEND;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign fifo_rd_en  = rd_en_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = strobe_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;

endmodule

// File: doc/fifo_uart_framer.md
Name: fifo_uart_framer

Overview:
- Reader/consumer end of the 48-bit TDC measurement FIFO; the measurement controller writes records, this block drains them.
- Pops one 48-bit record at a time and frames it as 8 bytes: SYNC, 6 data bytes MSB first, XOR checksum.
- Feeds the bytes to the existing byte-wide UART transmitter through its data/new_data/busy handshake.

Parameters:
- DATA_WIDTH, 48, record width; must be a multiple of 8 (6 bytes at default).
- SYNC_BYTE, 8'hA5, first byte of every frame.
- FIFO_RD_LATENCY, 1, cycles from the fifo_rd_en pulse to valid fifo_dout (1 or 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  48  FIFO read data, format {16'b0, calib_diff[15:0], time1[15:0]}.
- fifo_rd_en  out  1  single-cycle FIFO pop strobe.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  byte to the UART.
- new_tx_data  out  1  single-cycle strobe; the UART samples tx_data on this strobe.
- hold  in  1  pause input; no new frame starts while high.
- frame_done  out  1  single-cycle pulse after the checksum byte is handed to the UART.
- frame_count  out  16  frames completed; wraps 0xFFFF -> 0.

Behaviour:
- Reset values (async, rst_n=0): state IDLE; fifo_rd_en=0, new_tx_data=0, tx_data=0, frame_done=0, frame_count=0; latched record=0; checksum=0; byte index=0.
- All outputs are registered.
- States:
  - IDLE: if !fifo_empty && !hold, assert fifo_rd_en for exactly one cycle and go to RD_WAIT.
  - RD_WAIT: count FIFO_RD_LATENCY cycles, then latch fifo_dout into the record register, clear the checksum, set byte index=0, go to SEND.
  - SEND: when tx_busy==0, drive tx_data, pulse new_tx_data for one cycle, go to GUARD.
    - Byte index 0: SYNC_BYTE.
    - Byte indices 1..6: record[47:40], record[39:32], ..., record[7:0].
    - Byte index 7: checksum.
  - GUARD: one cycle with no action; covers the UART's one-cycle busy assertion latency. Then:
    - index==7: pulse frame_done, increment frame_count, go to IDLE.
    - otherwise: increment index, go to SEND.
- Checksum: XOR of the 6 data bytes only (SYNC excluded), updated as each data byte is issued.
- tx_data holds its value until the next new_tx_data strobe.
- Minimum byte spacing is 2 cycles: new_tx_data is never asserted in two consecutive cycles.
- hold is sampled only in IDLE; a frame in progress always completes.
- fifo_empty is sampled only in IDLE; exactly one pop per frame.
- A pop is never issued while fifo_empty=1, so there is no underflow.
- Back-to-back records: the next pop can occur the cycle after frame_done, giving no idle gap beyond the IDLE cycle.
- rst_n asserted mid-frame: the frame is aborted immediately and all outputs clear. A partially sent frame is not resumed; the host resynchronises on SYNC_BYTE plus checksum.
- tx_busy stuck high: the block waits indefinitely in SEND; no timeout.

Test Plan:
- Reset then one record 48'h0000_1234_ABCD, tx_busy always 0 -> fifo_rd_en one pulse; byte stream A5,00,00,12,34,AB,CD,checksum 0x40; 8 new_tx_data pulses spaced 2 cycles apart; frame_done one pulse; frame_count=1.
- UART model holds tx_busy high for 20 cycles after each strobe -> each new_tx_data occurs only after tx_busy falls; byte order unchanged; no strobe while busy.
- FIFO preloaded with 3 records, fifo_empty falls low once -> exactly 3 pops, 24 bytes, frame_count=3; no fifo_rd_en while fifo_empty=1.
- hold=1 asserted during byte 3 of frame 1, 2 records queued -> frame 1 completes all 8 bytes; no pop while hold=1; frame 2 starts within 2 cycles of hold falling.
- rst_n pulsed low after byte 4 -> outputs 0 asynchronously; after release with fifo_empty=0, a new pop occurs and a new frame starts with A5.
- frame_count preset near wrap via 65536 short frames (or forced) -> 0xFFFF -> 0x0000 on the next frame_done.
